// File: rtl/yauart_apb_completer.sv
// APB completer for the YAUART core: four-register map plus TX/RX byte FIFOs.
// TX bytes flow from APB writes to the core; RX bytes flow from the core to APB reads.
module yauart_apb_completer #(
  parameter int APB_AW      = 32,
  parameter int APB_DW      = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [APB_AW-1:0]   paddr_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [APB_DW-1:0]   pwdata_i,
  input  logic [APB_DW/8-1:0] pstrb_i,
  output logic                pready_o,
  output logic [APB_DW-1:0]   prdata_o,
  output logic                pslverr_o,
  output logic [7:0]          tx_data_o,
  output logic                tx_valid_o,
  input  logic                tx_ready_i,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_valid_i,
  output logic                rx_ready_o,
  output logic                irq_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [1:0]    WS_C    = 2'(WAIT_STATES);

  logic [1:0]    wait_cnt;
  logic          access;
  logic          done;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wptr;
  logic [PW-1:0] tx_rptr;
  logic [CW-1:0] tx_count;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wptr;
  logic [PW-1:0] rx_rptr;
  logic [CW-1:0] rx_count;

  logic          overrun;
  logic [1:0]    ctrl;

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          misaligned;
  logic [1:0]    reg_sel;
  logic          sel_data, sel_status, sel_ctrl, sel_levels;
  logic          err;
  logic          ok_wr, ok_rd;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          ovr_set, ovr_clr, ctrl_wr;
  logic [31:0]   rdata;
  logic          unused_bits;

  // Reset also forces pready low so an access interrupted by reset never completes.
  assign access   = psel_i & penable_i;
  assign pready_o = rst_n_i & access & (wait_cnt == WS_C);
  assign done     = access & pready_o;

  assign tx_full  = (tx_count == DEPTH_C);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == DEPTH_C);
  assign rx_empty = (rx_count == '0);

  assign misaligned = (paddr_i[1:0] != 2'b00);
  assign reg_sel    = paddr_i[3:2];
  assign sel_data   = (reg_sel == 2'd0);
  assign sel_status = (reg_sel == 2'd1);
  assign sel_ctrl   = (reg_sel == 2'd2);
  assign sel_levels = (reg_sel == 2'd3);

  // Full/empty tests use pre-edge counts, so a same-cycle core pop/push never rescues an access.
  assign err = misaligned
             | (pwrite_i & sel_levels)
             | (pwrite_i & sel_data & pstrb_i[0] & tx_full)
             | (!pwrite_i & sel_data & rx_empty);

  assign ok_wr = done & pwrite_i & !err;
  assign ok_rd = done & !pwrite_i & !err;

  assign tx_push = ok_wr & sel_data & pstrb_i[0];
  assign tx_pop  = tx_valid_o & tx_ready_i;
  assign rx_push = rx_valid_i & rx_ready_o;
  assign rx_pop  = ok_rd & sel_data;
  assign ovr_set = rx_valid_i & rx_full;
  assign ovr_clr = ok_wr & sel_status & pstrb_i[0] & pwdata_i[4];
  assign ctrl_wr = ok_wr & sel_ctrl & pstrb_i[0];

  assign tx_valid_o = !tx_empty;
  assign tx_data_o  = tx_mem[tx_rptr];
  assign rx_ready_o = !rx_full;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata = {24'b0, rx_mem[rx_rptr]};
      2'd1: rdata = {27'b0, overrun, rx_full, rx_empty, tx_full, tx_empty};
      2'd2: rdata = {30'b0, ctrl};
      2'd3: rdata = {16'b0, 8'(rx_count), 8'(tx_count)};
      default: rdata = '0;
    endcase
  end

  assign prdata_o  = ok_rd ? APB_DW'(rdata) : '0;
  assign pslverr_o = done & err;

  assign unused_bits = ^{paddr_i[APB_AW-1:4], pwdata_i[APB_DW-1:8], pstrb_i[APB_DW/8-1:1]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt <= '0;
    end else if (!psel_i || done) begin
      wait_cnt <= '0;
    end else if (access) begin
      wait_cnt <= wait_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem[i] <= '0;
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wptr] <= pwdata_i[7:0];
        tx_wptr         <= tx_wptr + PW'(1);
      end
      if (tx_pop) tx_rptr <= tx_rptr + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= '0;
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wptr] <= rx_data_i;
        rx_wptr         <= rx_wptr + PW'(1);
      end
      if (rx_pop) rx_rptr <= rx_rptr + PW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // A dropped byte in the same cycle as a clear leaves overrun set.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overrun <= 1'b0;
      ctrl    <= '0;
      irq_o   <= 1'b0;
    end else begin
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
      if (ctrl_wr) ctrl <= pwdata_i[1:0];
      irq_o <= (ctrl[0] & (!rx_empty | overrun)) | (ctrl[1] & tx_empty);
    end
  end

endmodule

// File: tb/tb_yauart_apb_completer.sv
// Scoreboard bench for yauart_apb_completer: a queue-based FIFO model predicts APB
// responses and TX bytes; monitors compare whenever the DUT completes or hands out a byte.
module tb_yauart_apb_completer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

  logic [31:0] w_paddr, w_pwdata, w_prdata;
  logic        w_psel, w_penable, w_pwrite, w_pready, w_pslverr;
  logic [3:0]  w_pstrb;
  logic [7:0]  w_tx_data, w_rx_data;
  logic        w_tx_valid, w_tx_ready, w_rx_valid, w_rx_ready, w_irq;

  yauart_apb_completer #(.FIFO_DEPTH(DEPTH), .WAIT_STATES(0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .paddr_i(paddr), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready),
    .prdata_o(prdata), .pslverr_o(pslverr), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready), .irq_o(irq));

  yauart_apb_completer #(.FIFO_DEPTH(DEPTH), .WAIT_STATES(2)) dut_ws (
    .clk_i(clk), .rst_n_i(rst_n), .paddr_i(w_paddr), .psel_i(w_psel), .penable_i(w_penable),
    .pwrite_i(w_pwrite), .pwdata_i(w_pwdata), .pstrb_i(w_pstrb), .pready_o(w_pready),
    .prdata_o(w_prdata), .pslverr_o(w_pslverr), .tx_data_o(w_tx_data), .tx_valid_o(w_tx_valid),
    .tx_ready_i(w_tx_ready), .rx_data_i(w_rx_data), .rx_valid_i(w_rx_valid),
    .rx_ready_o(w_rx_ready), .irq_o(w_irq));

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  rx_q[$];
  int          tx_cnt;
  bit          overrun;
  logic [1:0]  ctrl;
  int          checks = 0;
  int          errors = 0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] status_val();
    return {27'b0, overrun, rx_q.size() == DEPTH, rx_q.size() == 0, tx_cnt == DEPTH, tx_cnt == 0};
  endfunction

  function automatic logic model_irq();
    return (ctrl[0] && (rx_q.size() > 0 || overrun)) || (ctrl[1] && tx_cnt == 0);
  endfunction

  always @(negedge clk) begin
    if (psel && penable && pready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL apb_unexpected: completion with no expected response, prdata 0x%08h", prdata);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, " prdata"}, prdata, mon_e.data);
        check({mon_e.name, " pslverr"}, {31'b0, pslverr}, {31'b0, mon_e.err});
      end
    end
    if (tx_valid && tx_ready) begin
      if (exp_tx.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: byte 0x%02h with none expected", tx_data);
      end else begin
        check("tx_byte", {24'b0, tx_data}, {24'b0, exp_tx.pop_front()});
      end
    end
  end

  function automatic void model_reset();
    exp_tx.delete(); rx_q.delete();
    tx_cnt = 0; overrun = 1'b0; ctrl = 2'b00;
  endfunction

  // One APB transfer (setup + access) with optional core activity in the access cycle.
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input bit rxv, input logic [7:0] rxb,
                     input bit txr, input string name);
    logic [31:0] ed;
    bit ee, push_tx, pop_rx, clr, wrc, rx_ok, core_tx;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1; rx_valid = rxv; rx_data = rxb; tx_ready = txr;
    ed = '0; ee = 0; push_tx = 0; pop_rx = 0; clr = 0; wrc = 0;
    if (addr[1:0] != 2'b00) ee = 1;
    else case (addr[3:2])
      2'd0: if (wr) begin
              if (strb[0]) begin
                if (tx_cnt == DEPTH) ee = 1; else push_tx = 1;
              end
            end else if (rx_q.size() == 0) ee = 1;
            else begin ed = {24'b0, rx_q[0]}; pop_rx = 1; end
      2'd1: if (wr) clr = strb[0] && wdata[4]; else ed = status_val();
      2'd2: if (wr) wrc = strb[0]; else ed = {30'b0, ctrl};
      default: if (wr) ee = 1; else ed = {16'b0, 8'(rx_q.size()), 8'(tx_cnt)};
    endcase
    exp_q.push_back('{ed, ee, name});
    rx_ok   = rxv && rx_q.size() < DEPTH;
    core_tx = txr && tx_cnt > 0;
    @(posedge clk);
    if (pop_rx) void'(rx_q.pop_front());
    if (rx_ok) rx_q.push_back(rxb);
    if (clr) overrun = 1'b0;
    if (rxv && !rx_ok) overrun = 1'b1;
    if (core_tx) tx_cnt--;
    if (push_tx) begin tx_cnt++; exp_tx.push_back(wdata[7:0]); end
    if (wrc) ctrl = wdata[1:0];
    #1;
    psel = 0; penable = 0; rx_valid = 0; tx_ready = 0;
  endtask

  task automatic core(input bit rxv, input logic [7:0] rxb, input bit txr);
    bit rx_ok, core_tx;
    @(posedge clk); #1;
    rx_valid = rxv; rx_data = rxb; tx_ready = txr;
    rx_ok   = rxv && rx_q.size() < DEPTH;
    core_tx = txr && tx_cnt > 0;
    @(posedge clk);
    if (rx_ok) rx_q.push_back(rxb);
    if (rxv && !rx_ok) overrun = 1'b1;
    if (core_tx) tx_cnt--;
    #1;
    rx_valid = 0; tx_ready = 0;
  endtask

  task automatic check_idle(input string name);
    @(posedge clk); #1;
    check({name, " tx_valid"}, {31'b0, tx_valid}, {31'b0, tx_cnt > 0});
    check({name, " rx_ready"}, {31'b0, rx_ready}, {31'b0, rx_q.size() < DEPTH});
    check({name, " irq"}, {31'b0, irq}, {31'b0, model_irq()});
    if (tx_cnt > 0 && exp_tx.size() > 0)
      check({name, " tx_head"}, {24'b0, tx_data}, {24'b0, exp_tx[0]});
  endtask

  initial begin
    logic [31:0] base, a, d;
    logic [3:0]  s;
    int          kind;

    rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    w_psel = 0; w_penable = 0; w_pwrite = 0; w_paddr = '0; w_pwdata = '0; w_pstrb = '0;
    w_tx_ready = 0; w_rx_valid = 0; w_rx_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Leave state behind, then reset in the middle of an access.
    apb(1, 32'h8, 32'h1, 4'h1, 0, 8'h0, 0, "ctrl_wr_pre");
    apb(1, 32'h0, 32'h55, 4'h1, 0, 8'h0, 0, "tx_wr_pre");
    core(1, 8'hA5, 0);
    check_idle("pre_reset");
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 32'h0; pwdata = 32'h66; pstrb = 4'h1;
    @(posedge clk); #1;
    penable = 1;
    #1 rst_n = 0;
    #1;
    check("rst pready", {31'b0, pready}, 32'h0);
    check("rst tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst rx_ready", {31'b0, rx_ready}, 32'h1);
    check("rst irq", {31'b0, irq}, 32'h0);
    check("rst pslverr", {31'b0, pslverr}, 32'h0);
    psel = 0; penable = 0;
    model_reset();
    @(posedge clk); #1 rst_n = 1;
    apb(0, 32'h4, 0, 4'h0, 0, 8'h0, 0, "status_after_reset");
    apb(0, 32'hC, 0, 4'h0, 0, 8'h0, 0, "levels_after_reset");

    // TX path
    apb(1, 32'h0, 32'h41, 4'h1, 0, 8'h0, 0, "tx_wr_41");
    apb(1, 32'h0, 32'h42, 4'hF, 0, 8'h0, 0, "tx_wr_42");
    apb(0, 32'hC, 0, 4'h0, 0, 8'h0, 0, "levels_tx2");
    check_idle("tx_two");
    core(0, 8'h0, 1);
    core(0, 8'h0, 1);
    check_idle("tx_drained");
    apb(1, 32'h0, 32'h77, 4'h0, 0, 8'h0, 0, "tx_wr_nostrb");

    // TX full
    for (int i = 0; i < 9; i++) apb(1, 32'h0, 32'h60 + i, 4'h1, 0, 8'h0, 0, "tx_fill");
    apb(0, 32'hC, 0, 4'h0, 0, 8'h0, 0, "levels_tx_full");
    apb(0, 32'h4, 0, 4'h0, 0, 8'h0, 0, "status_tx_full");
    apb(1, 32'h0, 32'h99, 4'h1, 0, 8'h0, 1, "tx_wr_full_with_pop");
    for (int i = 0; i < 8; i++) core(0, 8'h0, 1);
    check_idle("tx_empty_again");

    // RX overrun
    for (int i = 1; i <= 9; i++) core(1, 8'(i), 0);
    check_idle("rx_full");
    apb(0, 32'h4, 0, 4'h0, 0, 8'h0, 0, "status_overrun");
    apb(1, 32'h4, 32'h10, 4'h1, 0, 8'h0, 0, "status_w1c");
    apb(0, 32'h4, 0, 4'h0, 0, 8'h0, 0, "status_cleared");
    for (int i = 0; i < 9; i++) apb(0, 32'h0, 0, 4'h0, 0, 8'h0, 0, "rx_drain");

    // Errors and simultaneous RX push/pop
    apb(0, 32'h2, 0, 4'h0, 0, 8'h0, 0, "misaligned_rd");
    apb(1, 32'hC, 32'hFFFF, 4'hF, 0, 8'h0, 0, "levels_wr");
    apb(1, 32'hB, 32'h3, 4'hF, 0, 8'h0, 0, "misaligned_ctrl_wr");
    apb(0, 32'h8, 0, 4'h0, 0, 8'h0, 0, "ctrl_unchanged");
    for (int i = 0; i < 4; i++) core(1, 8'hC0 + 8'(i), 0);
    apb(0, 32'h0, 0, 4'h0, 1, 8'hEE, 0, "rx_pop_push");
    apb(0, 32'hC, 0, 4'h0, 0, 8'h0, 0, "levels_rx4");
    apb(1, 32'h8, 32'h3, 4'h1, 0, 8'h0, 0, "ctrl_irq_on");
    check_idle("irq_rx");

    // Randomized mix
    for (int n = 0; n < 250; n++) begin
      base = $urandom() & 32'hFFFF_FFF0;
      kind = $urandom_range(0, 9);
      s    = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
      d    = $urandom();
      case (kind)
        0, 1: a = base | 32'h0;
        2:    a = base | 32'h4;
        3:    a = base | 32'h8;
        4:    a = base | 32'hC;
        5:    a = base | 32'($urandom_range(0, 15));
        default: a = base | 32'h0;
      endcase
      if (kind >= 8) core($urandom_range(0, 1) == 1, 8'($urandom()), $urandom_range(0, 1) == 1);
      else if (kind == 2 && d[4] == 1'b0)
        apb(0, a, d, s, $urandom_range(0, 2) == 0, 8'($urandom()), $urandom_range(0, 2) == 0, "rnd_rd");
      else
        apb($urandom_range(0, 1) == 1, a, d, s, $urandom_range(0, 2) == 0, 8'($urandom()),
            $urandom_range(0, 2) == 0, "rnd");
      check_idle("rnd_idle");
    end
    for (int i = 0; i < DEPTH && tx_cnt > 0; i++) core(0, 8'h0, 1);
    check_idle("final");

    // Wait-state instance: CTRL write with two wait cycles, then irq from empty TX.
    @(posedge clk); #1;
    w_psel = 1; w_penable = 0; w_pwrite = 1; w_paddr = 32'h8; w_pwdata = 32'h3; w_pstrb = 4'hF;
    @(posedge clk); #1;
    w_penable = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ws pready", {31'b0, w_pready}, {31'b0, i == 2});
      if (i == 2) check("ws pslverr", {31'b0, w_pslverr}, 32'h0);
      @(posedge clk);
    end
    #1;
    w_psel = 0; w_penable = 0;
    check("ws irq_before", {31'b0, w_irq}, 32'h0);
    @(posedge clk); #1;
    check("ws irq_after", {31'b0, w_irq}, 32'h1);
    w_psel = 1; w_pwrite = 0; w_paddr = 32'h8;
    @(posedge clk); #1;
    w_penable = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ws ctrl_rd pready", {31'b0, w_pready}, 32'h1);
    check("ws ctrl_rd data", w_prdata, 32'h3);
    @(posedge clk); #1;
    w_psel = 0; w_penable = 0;

    repeat (2) @(posedge clk);
    check("pending_apb", 32'(exp_q.size()), 32'h0);
    check("pending_tx", 32'(exp_tx.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
